// File: rtl/cu_pipe.sv
// cu_pipe: registered control unit for the gpp_calc datapath.
// One instruction per cycle; multi-cycle ALU ops via start/done handshake.
module cu_pipe #(
  parameter int          NREG       = 2,
  parameter int          IMMW       = 9,
  parameter logic [31:0] MC_MASK    = 32'h2000_0000,
  parameter int          MC_TIMEOUT = 255,
  localparam int         RAW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [5:0]      opcode,
  input  logic [RAW-1:0]  ra,
  input  logic [1:0]      ra_stack,
  input  logic [IMMW-1:0] imm,
  input  logic            mc_done,
  output logic            alu,
  output logic            bra,
  output logic            cond_bra,
  output logic            ld,
  output logic            st,
  output logic            tr,
  output logic            psh,
  output logic            pop,
  output logic            mov,
  output logic            flag_sel,
  output logic            acc_sel,
  output logic            pc_sel,
  output logic [3:0]      cond_sel,
  output logic [NREG-1:0] reg_sel,
  output logic            mc_start,
  output logic            mc_busy,
  output logic            retire,
  output logic            illegal,
  output logic            mc_err
);

  typedef struct packed {
    logic            alu;
    logic            bra;
    logic            cond_bra;
    logic            ld;
    logic            st;
    logic            tr;
    logic            psh;
    logic            pop;
    logic            mov;
    logic            flag_sel;
    logic            acc_sel;
    logic            pc_sel;
    logic [3:0]      cond_sel;
    logic [NREG-1:0] reg_sel;
    logic            mc_start;
    logic            mc_busy;
    logic            retire;
    logic            illegal;
    logic            mc_err;
    logic            ready;
  } ctl_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam int CW = $clog2(MC_TIMEOUT + 2);
  localparam int TL = (MC_TIMEOUT > 0) ? MC_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(TL);

  logic [1:0]      state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  ctl_t            q, nxt, dec;
  logic [RAW-1:0]  ra_q;
  logic            imm_z_q;
  logic            imm_z;
  logic            ra_ok;
  logic            use_ra;
  logic            d_ill;
  logic            d_mc;
  logic            accept;
  logic            latch;
  logic [NREG-1:0] rsel;

  assign imm_z = (imm == '0);
  assign ra_ok = (ra <= RAW'(NREG - 1));
  assign rsel  = NREG'(1) << ra;

  always_comb begin
    dec    = '0;
    use_ra = 1'b0;
    d_ill  = 1'b0;
    d_mc   = 1'b0;
    unique case (1'b1)
      (opcode <= 6'h01): begin
        dec.tr      = 1'b1;
        dec.reg_sel = NREG'(1) << opcode[0];
      end
      (opcode == 6'h02): begin
        dec.ld      = 1'b1;
        dec.reg_sel = rsel;
        use_ra      = 1'b1;
      end
      (opcode == 6'h03): begin
        dec.st      = 1'b1;
        dec.reg_sel = rsel;
        use_ra      = 1'b1;
      end
      (opcode == 6'h04), (opcode == 6'h05): begin
        dec.psh = !opcode[0];
        dec.st  = !opcode[0];
        dec.pop = opcode[0];
        dec.ld  = opcode[0];
        unique case (ra_stack)
          2'd0:    dec.reg_sel = NREG'(1);
          2'd1:    dec.reg_sel = NREG'(2);
          2'd2:    dec.acc_sel = 1'b1;
          default: dec.pc_sel  = 1'b1;
        endcase
      end
      (opcode >= 6'h06 && opcode <= 6'h09): begin
        dec.bra      = 1'b1;
        dec.cond_bra = 1'b1;
        dec.cond_sel = 4'b0001 << (opcode - 6'h06);
      end
      (opcode == 6'h0A): begin
        dec.bra = 1'b1;
      end
      (opcode >= 6'h0D && opcode <= 6'h1D): begin
        dec.alu      = 1'b1;
        dec.flag_sel = 1'b1;
        d_mc         = MC_MASK[opcode[4:0]];
        // CMP only updates flags
        if (opcode != 6'h14) begin
          if (opcode inside {6'h15, 6'h16, 6'h1A} || !imm_z) begin
            dec.reg_sel = rsel;
            use_ra      = 1'b1;
          end else begin
            dec.acc_sel = 1'b1;
          end
        end
      end
      (opcode == 6'h1E): begin
        dec.mov     = 1'b1;
        dec.reg_sel = rsel;
        use_ra      = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (use_ra && !ra_ok) d_ill = 1'b1;
    if (d_ill) begin
      dec  = '0;
      d_mc = 1'b0;
    end
  end

  assign accept = instr_valid && q.ready;

  always_comb begin
    nxt    = '0;
    nstate = S_IDLE;
    ncnt   = cnt;
    latch  = 1'b0;
    if (state == S_WAIT) begin
      // done is ignored in the start cycle
      if (!q.mc_start && mc_done) begin
        nstate     = S_WB;
        nxt.alu    = 1'b1;
        nxt.retire = 1'b1;
        nxt.ready  = 1'b1;
        if (imm_z_q) nxt.acc_sel = 1'b1;
        else         nxt.reg_sel = NREG'(1) << ra_q;
      end else if (MC_TIMEOUT != 0 && cnt == TMO_LAST) begin
        nxt.mc_err = 1'b1;
        nxt.ready  = 1'b1;
      end else begin
        nstate       = S_WAIT;
        nxt.alu      = 1'b1;
        nxt.flag_sel = 1'b1;
        nxt.mc_busy  = 1'b1;
        if (cnt != '1) ncnt = cnt + 1'b1;
      end
    end else begin
      nxt.ready = 1'b1;
      if (accept) begin
        latch = 1'b1;
        if (d_mc) begin
          nstate       = S_WAIT;
          nxt.alu      = 1'b1;
          nxt.flag_sel = 1'b1;
          nxt.mc_busy  = 1'b1;
          nxt.mc_start = 1'b1;
          nxt.ready    = 1'b0;
          ncnt         = '0;
        end else begin
          nstate      = S_EXEC;
          nxt         = dec;
          nxt.retire  = !d_ill;
          nxt.illegal = d_ill;
          nxt.ready   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      q       <= '0;
      ra_q    <= '0;
      imm_z_q <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      q     <= nxt;
      if (latch) begin
        ra_q    <= ra;
        imm_z_q <= imm_z;
      end
    end
  end

  assign instr_ready = q.ready;
  assign alu         = q.alu;
  assign bra         = q.bra;
  assign cond_bra    = q.cond_bra;
  assign ld          = q.ld;
  assign st          = q.st;
  assign tr          = q.tr;
  assign psh         = q.psh;
  assign pop         = q.pop;
  assign mov         = q.mov;
  assign flag_sel    = q.flag_sel;
  assign acc_sel     = q.acc_sel;
  assign pc_sel      = q.pc_sel;
  assign cond_sel    = q.cond_sel;
  assign reg_sel     = q.reg_sel;
  assign mc_start    = q.mc_start;
  assign mc_busy     = q.mc_busy;
  assign retire      = q.retire;
  assign illegal     = q.illegal;
  assign mc_err      = q.mc_err;

endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: scoreboard bench for cu_pipe with random instruction stream.
// Expected responses come from a transaction-level model of the decode rules.
module tb_cu_pipe;

  localparam int          NREG = 3;
  localparam int          IMMW = 9;
  localparam int          RAW  = 2;
  localparam int          TMO  = 5;
  localparam logic [31:0] MASK = 32'h2002_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic            instr_ready;
  logic [5:0]      opcode;
  logic [RAW-1:0]  ra;
  logic [1:0]      ra_stack;
  logic [IMMW-1:0] imm;
  logic            mc_done;
  logic            alu, bra, cond_bra, ld, st, tr, psh, pop, mov;
  logic            flag_sel, acc_sel, pc_sel;
  logic [3:0]      cond_sel;
  logic [NREG-1:0] reg_sel;
  logic            mc_start, mc_busy, retire, illegal, mc_err;

  cu_pipe #(
    .NREG(NREG), .IMMW(IMMW), .MC_MASK(MASK), .MC_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .ra(ra), .ra_stack(ra_stack), .imm(imm),
    .mc_done(mc_done),
    .alu(alu), .bra(bra), .cond_bra(cond_bra), .ld(ld), .st(st),
    .tr(tr), .psh(psh), .pop(pop), .mov(mov),
    .flag_sel(flag_sel), .acc_sel(acc_sel), .pc_sel(pc_sel),
    .cond_sel(cond_sel), .reg_sel(reg_sel),
    .mc_start(mc_start), .mc_busy(mc_busy), .retire(retire),
    .illegal(illegal), .mc_err(mc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [21+NREG:0] all_out = {instr_ready, alu, bra, cond_bra, ld, st,
    tr, psh, pop, mov, flag_sel, acc_sel, pc_sel, cond_sel, reg_sel,
    mc_start, mc_busy, retire, illegal, mc_err};

  typedef struct packed {
    logic            alu, bra, cond_bra, ld, st, tr, psh, pop, mov;
    logic            flag_sel, acc_sel, pc_sel;
    logic [3:0]      cond_sel;
    logic [NREG-1:0] reg_sel;
    logic            retire, illegal, mc_err;
    logic [7:0]      busy_len;
    logic [3:0]      starts;
    logic [3:0]      busy_rdy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;

  function automatic logic [NREG-1:0] onehot(input int i);
    logic [NREG-1:0] r = '0;
    if (i >= 0 && i < NREG) r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit is_mc(input int op);
    return op >= 13 && op <= 29 && ((MASK >> op) & 32'd1) != 0;
  endfunction

  // Outcome of one instruction; d = cycles from mc_start to mc_done.
  function automatic obs_t model(input int op, input int r, input int rs,
                                 input int im, input int d);
    obs_t e = '0;
    bit   need_ra = 1'b0;
    bit   bad = (op == 11) || (op == 12) || (op > 30);
    if (op <= 1) begin
      e.tr = 1'b1;
      e.reg_sel = onehot(op);
    end else if (op == 2 || op == 3) begin
      e.ld = (op == 2);
      e.st = (op == 3);
      e.reg_sel = onehot(r);
      need_ra = 1'b1;
    end else if (op == 4 || op == 5) begin
      e.psh = (op == 4);
      e.st  = (op == 4);
      e.pop = (op == 5);
      e.ld  = (op == 5);
      if (rs < 2)       e.reg_sel = onehot(rs);
      else if (rs == 2) e.acc_sel = 1'b1;
      else              e.pc_sel = 1'b1;
    end else if (op >= 6 && op <= 10) begin
      e.bra = 1'b1;
      if (op < 10) begin
        e.cond_bra = 1'b1;
        e.cond_sel[op-6] = 1'b1;
      end
    end else if (op >= 13 && op <= 29) begin
      e.alu = 1'b1;
      e.flag_sel = 1'b1;
      if (op == 21 || op == 22 || op == 26) begin
        e.reg_sel = onehot(r);
        need_ra = 1'b1;
      end else if (op != 20) begin
        if (im == 0) e.acc_sel = 1'b1;
        else begin
          e.reg_sel = onehot(r);
          need_ra = 1'b1;
        end
      end
    end else if (op == 30) begin
      e.mov = 1'b1;
      e.reg_sel = onehot(r);
      need_ra = 1'b1;
    end
    if (need_ra && r >= NREG) bad = 1'b1;
    if (bad) begin
      e = '0;
      e.illegal = 1'b1;
      return e;
    end
    if (is_mc(op)) begin
      e = '0;
      e.starts = 4'd1;
      if (d < TMO) begin
        e.alu = 1'b1;
        e.retire = 1'b1;
        e.busy_len = 8'(d + 1);
        if (im == 0) e.acc_sel = 1'b1;
        else         e.reg_sel = onehot(r);
      end else begin
        e.mc_err = 1'b1;
        e.busy_len = 8'(TMO);
      end
      return e;
    end
    e.retire = 1'b1;
    return e;
  endfunction

  task automatic issue(input int op, input int r, input int rs,
                       input int im, input int d);
    exp_t x;
    int   a;
    int   n = 0;
    opcode      = 6'(op);
    ra          = RAW'(r);
    ra_stack    = 2'(rs);
    imm         = IMMW'(im);
    instr_valid = 1'b1;
    mc_done     = 1'($urandom_range(1));
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      vecs++;
      errs++;
      $display("FAIL accept_wait op=%0d ready=%b required=1", op, instr_ready);
      instr_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    x.o = model(op, r, rs, im, d);
    if (x.o.starts == 0) x.cyc = a;
    else if (d < TMO)    x.cyc = a + d + 1;
    else                 x.cyc = a + TMO;
    sbq.push_back(x);
    @(negedge clk);
    instr_valid = 1'b0;
    mc_done = 1'($urandom_range(1));
    if (x.o.starts != 0) begin
      while (cyc < x.cyc) begin
        @(negedge clk);
        mc_done = (cyc == a + d);
      end
      mc_done = 1'($urandom_range(1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      opcode  = 6'($urandom);
      mc_done = 1'($urandom_range(1));
    end
  endtask

  int blen = 0;
  int brdy = 0;
  int bst  = 0;

  always @(negedge clk) begin
    obs_t o;
    obs_t qe;
    exp_t x;
    if (!rst) begin
      blen = 0;
      brdy = 0;
      bst  = 0;
    end else begin
      if (mc_busy) begin
        blen++;
        if (instr_ready) brdy++;
      end
      if (mc_start) bst++;
      o = '0;
      o.alu = alu;       o.bra = bra;     o.cond_bra = cond_bra;
      o.ld = ld;         o.st = st;       o.tr = tr;
      o.psh = psh;       o.pop = pop;     o.mov = mov;
      o.flag_sel = flag_sel;
      o.acc_sel = acc_sel;
      o.pc_sel = pc_sel;
      o.cond_sel = cond_sel;
      o.reg_sel = reg_sel;
      o.retire = retire; o.illegal = illegal; o.mc_err = mc_err;
      vecs++;
      if (retire || illegal || mc_err) begin
        o.busy_len = 8'(blen);
        o.starts   = 4'(bst);
        o.busy_rdy = 4'(brdy);
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_event cyc=%0d got=%h required=none",
                   cyc, o);
        end else begin
          x = sbq.pop_front();
          if (o !== x.o || cyc != x.cyc) begin
            errs++;
            $display("FAIL result cyc=%0d got=%h required=%h at cyc=%0d",
                     cyc, o, x.o, x.cyc);
          end
        end
        blen = 0;
        brdy = 0;
        bst  = 0;
      end else begin
        qe = '0;
        qe.alu = mc_busy;
        qe.flag_sel = mc_busy;
        if (o !== qe) begin
          errs++;
          $display("FAIL quiet cyc=%0d got=%h required=%h", cyc, o, qe);
        end
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          errs++;
          x = sbq.pop_front();
          $display("FAIL missing cyc=%0d got=no event required=%h",
                   cyc, x.o);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=no finish required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int op, r, rs, im, d;
    rst = 1'b0;
    instr_valid = 1'b0;
    opcode = '0; ra = '0; ra_stack = '0; imm = '0; mc_done = 1'b0;
    #12;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%h required=0", all_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (instr_ready !== 1'b0) begin
      errs++;
      $display("FAIL ready_pre got=%b required=0", instr_ready);
    end
    @(negedge clk);
    vecs++;
    if (instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_rise got=%b required=1", instr_ready);
    end

    issue(1, 0, 0, 0, 0);
    issue(2, 0, 0, 0, 0);
    issue(13, 0, 0, 0, 0);
    issue(13, 1, 0, 5, 0);
    issue(5, 0, 3, 0, 0);
    issue(6, 0, 0, 0, 0);
    idle(2);
    issue(29, 1, 0, 1, TMO - 1);
    issue(29, 0, 0, 0, TMO + 2);
    issue(11, 0, 0, 0, 0);
    issue(63, 0, 0, 0, 0);
    issue(2, 3, 0, 0, 0);
    issue(17, 2, 0, 7, 1);
    issue(29, 0, 0, 0, TMO);
    issue(20, 3, 0, 9, 0);

    repeat (400) begin
      if ($urandom_range(99) < 15) op = ($urandom_range(1) == 0) ? 17 : 29;
      else if ($urandom_range(99) < 80) op = int'($urandom_range(30));
      else op = int'($urandom_range(63));
      r  = int'($urandom_range(3));
      rs = int'($urandom_range(3));
      im = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(511));
      d  = int'($urandom_range(TMO + 1, 1));
      issue(op, r, rs, im, d);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
    end
    idle(TMO + 10);

    opcode = 6'd29; ra = '0; imm = '0; mc_done = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (mc_busy !== 1'b1) begin
      errs++;
      $display("FAIL busy_before_reset got=%b required=1", mc_busy);
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_mid_wait got=%h required=0", all_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_after_reset got=%b required=1", instr_ready);
    end
    issue(30, 2, 0, 0, 0);
    issue(3, 1, 0, 0, 0);
    idle(TMO + 4);

    vecs++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d pending required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
